cache_fill_ctrl: RTL and testbench

- Multi-requester cache-miss fill controller for the pipelined CPU.
- Accepts miss requests from NUM_REQ caches (index 0 = D-cache, 1 = I-cache) and grants one at a time.
- Streams one block of WORDS_PER_BLK words from pipelined main memory into the granted cache's data array, then writes its tag.
- Drives the pipeline stall while any miss is pending or being filled.
- Generalises the fixed 2-way/8-word single-cache miss FSM to any requester count and block size, with in-order returns of arbitrary latency.

---
 rtl/cache_fill_if.sv | 47 ++++
 rtl/cache_fill_ctrl.sv | 154 +++++++++++++++
 tb/tb_cache_fill_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_fill_if.sv
// Bundle between the fill controller, the requesting caches and pipelined main memory.
// crit_o exists only when CRITICAL_WORD_FIRST_EN is defined.
interface cache_fill_if #(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned WORDS_PER_BLK = 8,
    parameter int unsigned NUM_REQ       = 2
);
    localparam int unsigned OFF_W = $clog2(WORDS_PER_BLK);
    localparam int unsigned GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        miss_i;
    logic [NUM_REQ*ADDR_W-1:0] miss_addr_i;
    logic                      mem_req_o;
    logic [ADDR_W-1:0]         mem_addr_o;
    logic                      mem_rvalid_i;
    logic [DATA_W-1:0]         mem_rdata_i;
    logic [NUM_REQ-1:0]        data_we_o;
    logic [OFF_W-1:0]          data_word_o;
    logic [DATA_W-1:0]         data_wdata_o;
    logic [NUM_REQ-1:0]        tag_we_o;
    logic [NUM_REQ-1:0]        done_o;
    logic [GNT_W-1:0]          gnt_o;
    logic                      busy_o;
    logic                      stall_o;
`ifdef CRITICAL_WORD_FIRST_EN
    logic                      crit_o;
`endif

    modport master (
        input  miss_i, miss_addr_i, mem_rvalid_i, mem_rdata_i,
        output mem_req_o, mem_addr_o, data_we_o, data_word_o, data_wdata_o,
               tag_we_o, done_o, gnt_o, busy_o, stall_o
`ifdef CRITICAL_WORD_FIRST_EN
        , output crit_o
`endif
    );

    modport slave (
        output miss_i, miss_addr_i, mem_rvalid_i, mem_rdata_i,
        input  mem_req_o, mem_addr_o, data_we_o, data_word_o, data_wdata_o,
               tag_we_o, done_o, gnt_o, busy_o, stall_o
`ifdef CRITICAL_WORD_FIRST_EN
        , input crit_o
`endif
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Multi-requester cache-miss fill controller: grants one miss at a time, streams a block from
// pipelined memory into the granted cache, then writes its tag. Optional: CRITICAL_WORD_FIRST_EN.
module cache_fill_ctrl #(
    parameter int unsigned ADDR_W        = 16,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned WORDS_PER_BLK = 8,
    parameter int unsigned NUM_REQ       = 2
) (
    input logic         clk,
    input logic         rst_n,
    cache_fill_if.master bus
);
    localparam int unsigned OFF_W = $clog2(WORDS_PER_BLK);
    localparam int unsigned CNT_W = OFF_W + 1;
    localparam int unsigned GNT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(WORDS_PER_BLK);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WORDS_PER_BLK - 1);
    localparam logic [ADDR_W-1:0] BLK_MASK  = ADDR_W'(2 * WORDS_PER_BLK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic               busy;
    logic [GNT_W-1:0]   gnt;
    logic [ADDR_W-1:0]  base;
    logic [OFF_W-1:0]   startOff;
    logic [CNT_W-1:0]   issueCnt;
    logic [CNT_W-1:0]   retCnt;

    logic [GNT_W-1:0]   pickIdx;
    logic [ADDR_W-1:0]  pickAddr;
    logic               pickFound;
    logic [OFF_W-1:0]   issueOff;
    logic [OFF_W-1:0]   retOff;
    logic               issueOk;
    logic               retOk;
    logic [NUM_REQ-1:0] gntOneHot;

    // Fixed priority: the lowest asserted requester wins.
    always_comb begin
        pickIdx   = '0;
        pickAddr  = '0;
        pickFound = 1'b0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (bus.miss_i[k] && !pickFound) begin
                pickIdx   = GNT_W'(k);
                pickAddr  = bus.miss_addr_i[k*ADDR_W +: ADDR_W];
                pickFound = 1'b1;
            end
        end
    end

    assign issueOff  = startOff + issueCnt[OFF_W-1:0];
    assign retOff    = startOff + retCnt[OFF_W-1:0];
    assign issueOk   = (state == FILL) && (issueCnt < FULL_CNT);
    assign retOk     = (state == FILL) && bus.mem_rvalid_i && (retCnt < FULL_CNT);
    assign gntOneHot = NUM_REQ'(1) << gnt;

`ifdef CRITICAL_WORD_FIRST_EN
    // Wrap point of the fill is the word that actually missed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            startOff <= '0;
        end else if (state == IDLE && pickFound) begin
            startOff <= pickAddr[OFF_W:1];
        end
    end
`else
    assign startOff = '0;
`endif

    // State, grant latch and issue/return counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            gnt      <= '0;
            base     <= '0;
            issueCnt <= '0;
            retCnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pickFound) begin
                        state    <= FILL;
                        busy     <= 1'b1;
                        gnt      <= pickIdx;
                        base     <= pickAddr & ~BLK_MASK;
                        issueCnt <= '0;
                        retCnt   <= '0;
                    end
                end
                FILL: begin
                    if (issueOk) begin
                        issueCnt <= issueCnt + CNT_W'(1);
                    end
                    if (retOk) begin
                        retCnt <= retCnt + CNT_W'(1);
                        if (retCnt == LAST_CNT) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Memory issue, array writes and completion decoded from the registered state.
    always_comb begin
        bus.mem_req_o    = 1'b0;
        bus.mem_addr_o   = '0;
        bus.data_we_o    = '0;
        bus.data_word_o  = '0;
        bus.data_wdata_o = '0;
        bus.tag_we_o     = '0;
        bus.done_o       = '0;
`ifdef CRITICAL_WORD_FIRST_EN
        bus.crit_o       = 1'b0;
`endif
        if (issueOk) begin
            bus.mem_req_o  = 1'b1;
            bus.mem_addr_o = base + ADDR_W'({issueOff, 1'b0});
        end
        if (retOk) begin
            bus.data_we_o    = gntOneHot;
            bus.data_word_o  = retOff;
            bus.data_wdata_o = bus.mem_rdata_i;
`ifdef CRITICAL_WORD_FIRST_EN
            bus.crit_o       = (retCnt == '0);
`endif
        end
        if (state == DONE) begin
            bus.tag_we_o = gntOneHot;
            bus.done_o   = gntOneHot;
        end
    end

    assign bus.gnt_o   = gnt;
    assign bus.busy_o  = busy;
    assign bus.stall_o = busy | (|bus.miss_i);

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: a cycle table for the basic fill plus sequences for
// arbitration, irregular returns, reset mid-fill and a 4-word single-requester instance.
module tb_cache_fill_ctrl;
`ifdef CRITICAL_WORD_FIRST_EN
    localparam int START_A = 3;
`else
    localparam int START_A = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cache_fill_if #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLK(8), .NUM_REQ(2)) busA ();
    cache_fill_if #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLK(4), .NUM_REQ(1)) busB ();

    cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLK(8), .NUM_REQ(2)) dutA (
        .clk(clk), .rst_n(rst_n), .bus(busA));
    cache_fill_ctrl #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLK(4), .NUM_REQ(1)) dutB (
        .clk(clk), .rst_n(rst_n), .bus(busB));

    logic [1:0]  missA;
    logic [31:0] addrA;
    logic        missB;
    logic [15:0] addrB;
    logic        rvalid;
    logic [15:0] rdata;

    assign busA.miss_i       = missA;
    assign busA.miss_addr_i  = addrA;
    assign busA.mem_rvalid_i = rvalid;
    assign busA.mem_rdata_i  = rdata;
    assign busB.miss_i       = missB;
    assign busB.miss_addr_i  = addrB;
    assign busB.mem_rvalid_i = rvalid;
    assign busB.mem_rdata_i  = rdata;

    int sel;
    logic        obsReq, obsGnt, obsBusy, obsStall;
    logic [15:0] obsAddr, obsWdata;
    logic [1:0]  obsWe, obsTag, obsDone;
    logic [2:0]  obsWord;
`ifdef CRITICAL_WORD_FIRST_EN
    logic        obsCrit;
    assign obsCrit = (sel == 1) ? busB.crit_o : busA.crit_o;
`endif

    always_comb begin
        if (sel == 1) begin
            obsReq   = busB.mem_req_o;
            obsAddr  = busB.mem_addr_o;
            obsWe    = 2'(busB.data_we_o);
            obsWord  = 3'(busB.data_word_o);
            obsWdata = busB.data_wdata_o;
            obsTag   = 2'(busB.tag_we_o);
            obsDone  = 2'(busB.done_o);
            obsGnt   = busB.gnt_o;
            obsBusy  = busB.busy_o;
            obsStall = busB.stall_o;
        end else begin
            obsReq   = busA.mem_req_o;
            obsAddr  = busA.mem_addr_o;
            obsWe    = busA.data_we_o;
            obsWord  = busA.data_word_o;
            obsWdata = busA.data_wdata_o;
            obsTag   = busA.tag_we_o;
            obsDone  = busA.done_o;
            obsGnt   = busA.gnt_o;
            obsBusy  = busA.busy_o;
            obsStall = busA.stall_o;
        end
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [1:0]  miss;
        logic        rv;
        logic [15:0] rd;
        logic        req;
        logic [15:0] addr;
        logic [1:0]  we;
        logic [2:0]  word;
        logic [1:0]  tag;
        logic        busy;
        logic        stall;
    } vec_t;

    function automatic vec_t mk(logic [1:0] miss, logic rv, logic [15:0] rd, logic req,
                                logic [15:0] addr, logic [1:0] we, logic [2:0] word,
                                logic [1:0] tag, logic busy, logic stall);
        vec_t v;
        v = '{miss, rv, rd, req, addr, we, word, tag, busy, stall};
        return v;
    endfunction

    function automatic logic [2:0] offA(int i);
        return 3'((START_A + i) % 8);
    endfunction

    // One complete fill on the selected DUT, starting in the IDLE cycle where the miss is seen.
    // Memory returns in order, no earlier than lat cycles after issue and gap[i] idle cycles
    // after the previous return.
    task automatic run_fill(input int s, input int reqIdx, input logic [15:0] addr,
                            input int nWords, input int lat, input int gap[8]);
        int issCyc[$];
        int nRet = 0;
        int lastRet = -100;
        int c = 1;
        int start = 0;
        bit doneSeen = 0;
        bit rv;
        logic [15:0] base;
        logic [1:0]  oneHot;
        base   = addr & ~16'(2 * nWords - 1);
        oneHot = 2'(1 << reqIdx);
`ifdef CRITICAL_WORD_FIRST_EN
        start = int'(addr >> 1) % nWords;
`endif
        sel    = s;
        rvalid = 1'b0;
        @(negedge clk);
        chk("accept_busy", 32'(obsBusy), 0);
        chk("accept_stall", 32'(obsStall), 1);
        chk("accept_tag", 32'(obsTag), 0);
        chk("accept_done", 32'(obsDone), 0);
        next_cycle();
        while (!doneSeen && c < 100) begin
            rv = (nRet < issCyc.size()) && (nRet < nWords) &&
                 (c >= issCyc[nRet] + lat) && (c >= lastRet + 1 + gap[nRet]);
            rvalid = rv;
            rdata  = rv ? 16'(32'hA000 + nRet) : 16'hDEAD;
            @(negedge clk);
            chk("fill_busy", 32'(obsBusy), 1);
            chk("fill_stall", 32'(obsStall), 1);
            if (c == 1) chk("fill_gnt", 32'(obsGnt), 32'(reqIdx));
            if (obsReq) begin
                if (issCyc.size() >= nWords) chk("extra_issue", 32'(issCyc.size()), 32'(nWords - 1));
                else chk($sformatf("issue%0d_addr", issCyc.size()), 32'(obsAddr),
                         32'(base + 16'(2 * ((start + issCyc.size()) % nWords))));
                issCyc.push_back(c);
            end
            if (rv) begin
                chk($sformatf("ret%0d_we", nRet), 32'(obsWe), 32'(oneHot));
                chk($sformatf("ret%0d_word", nRet), 32'(obsWord), 32'((start + nRet) % nWords));
                chk($sformatf("ret%0d_wdata", nRet), 32'(obsWdata), 32'hA000 + 32'(nRet));
`ifdef CRITICAL_WORD_FIRST_EN
                chk($sformatf("ret%0d_crit", nRet), 32'(obsCrit), (nRet == 0) ? 1 : 0);
`endif
                nRet++;
                lastRet = c;
            end else begin
                chk("idle_we", 32'(obsWe), 0);
            end
            if (obsTag != 0 || obsDone != 0) begin
                chk("done_tag", 32'(obsTag), 32'(oneHot));
                chk("done_pulse", 32'(obsDone), 32'(oneHot));
                chk("done_after_last_ret", 32'(nRet), 32'(nWords));
                chk("done_timing", 32'(lastRet), 32'(c - 1));
                chk("done_issue_count", 32'(issCyc.size()), 32'(nWords));
                doneSeen = 1;
            end
            next_cycle();
            c++;
        end
        rvalid = 1'b0;
        if (!doneSeen) chk("fill_timeout", 32'(c), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[15];
        int zg[8];
        int ig[8];
        zg = '{default: 0};
        ig = '{0, 3, 1, 5, 0, 2, 4, 1};

        // Basic fill: miss at 0x1236 on requester 0, memory latency 4.
        tbl[0] = mk(2'b01, 1'b0, 16'h0, 1'b0, 16'h0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b1);
        for (int r = 1; r <= 4; r++)
            tbl[r] = mk(2'b01, 1'b0, 16'h0, 1'b1, 16'h1230 + 16'(2 * offA(r - 1)),
                        2'b00, 3'd0, 2'b00, 1'b1, 1'b1);
        for (int r = 5; r <= 8; r++)
            tbl[r] = mk(2'b01, 1'b1, 16'h5000 + 16'(r - 5), 1'b1, 16'h1230 + 16'(2 * offA(r - 1)),
                        2'b01, offA(r - 5), 2'b00, 1'b1, 1'b1);
        for (int r = 9; r <= 12; r++)
            tbl[r] = mk(2'b01, 1'b1, 16'h5000 + 16'(r - 5), 1'b0, 16'h0,
                        2'b01, offA(r - 5), 2'b00, 1'b1, 1'b1);
        tbl[13] = mk(2'b01, 1'b0, 16'h0, 1'b0, 16'h0, 2'b00, 3'd0, 2'b01, 1'b1, 1'b1);
        tbl[14] = mk(2'b00, 1'b0, 16'h0, 1'b0, 16'h0, 2'b00, 3'd0, 2'b00, 1'b0, 1'b0);

        sel = 0; rst_n = 1'b0; missA = '0; addrA = '0; missB = 1'b0; addrB = '0;
        rvalid = 1'b0; rdata = '0;
        #2;
        chk("rst_req", 32'(obsReq), 0);
        chk("rst_busy", 32'(obsBusy), 0);
        chk("rst_we", 32'(obsWe), 0);
        chk("rst_tag", 32'(obsTag), 0);
        chk("rst_done", 32'(obsDone), 0);
        chk("rst_gnt", 32'(obsGnt), 0);
        chk("rst_stall", 32'(obsStall), 0);
        missA = 2'b10;
        #1;
        chk("rst_stall_follows_miss", 32'(obsStall), 1);
        chk("rst_busy_with_miss", 32'(obsBusy), 0);
        missA = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        next_cycle();

        addrA = {16'h0000, 16'h1236};
        for (int r = 0; r < 15; r++) begin
            missA = tbl[r].miss; rvalid = tbl[r].rv; rdata = tbl[r].rd;
            @(negedge clk);
            chk($sformatf("vec%0d_req", r), 32'(obsReq), 32'(tbl[r].req));
            if (tbl[r].req) chk($sformatf("vec%0d_addr", r), 32'(obsAddr), 32'(tbl[r].addr));
            chk($sformatf("vec%0d_we", r), 32'(obsWe), 32'(tbl[r].we));
            if (tbl[r].we != 0) begin
                chk($sformatf("vec%0d_word", r), 32'(obsWord), 32'(tbl[r].word));
                chk($sformatf("vec%0d_wdata", r), 32'(obsWdata), 32'(tbl[r].rd));
            end
            chk($sformatf("vec%0d_tag", r), 32'(obsTag), 32'(tbl[r].tag));
            chk($sformatf("vec%0d_done", r), 32'(obsDone), 32'(tbl[r].tag));
            chk($sformatf("vec%0d_busy", r), 32'(obsBusy), 32'(tbl[r].busy));
            chk($sformatf("vec%0d_stall", r), 32'(obsStall), 32'(tbl[r].stall));
            next_cycle();
        end
        rvalid = 1'b0;

        // Simultaneous misses: requester 0 first, requester 1 in the IDLE cycle after DONE.
        missA = 2'b11;
        addrA = {16'h2040, 16'h1000};
        run_fill(0, 0, 16'h1000, 8, 1, zg);
        missA = 2'b10;
        run_fill(0, 1, 16'h2040, 8, 1, zg);
        missA = 2'b00;
        @(negedge clk);
        chk("arb_idle_busy", 32'(obsBusy), 0);
        chk("arb_idle_stall", 32'(obsStall), 0);
        next_cycle();

        // Irregular return gaps.
        missA = 2'b10;
        addrA = {16'h4A50, 16'h0000};
        run_fill(0, 1, 16'h4A50, 8, 2, ig);
        missA = 2'b00;
        next_cycle();

        // Reset during the 5th return, then stray returns.
        missA = 2'b01;
        addrA = {16'h0000, 16'h3000};
        for (int c = 0; c <= 8; c++) begin
            rvalid = (c >= 5);
            rdata  = 16'h7000 + 16'(c);
            @(negedge clk);
            chk($sformatf("pre_rst%0d_tag", c), 32'(obsTag), 0);
            chk($sformatf("pre_rst%0d_we", c), 32'(obsWe), (c >= 5) ? 1 : 0);
            next_cycle();
        end
        rvalid = 1'b1;
        rst_n  = 1'b0;
        @(negedge clk);
        chk("midrst_req", 32'(obsReq), 0);
        chk("midrst_we", 32'(obsWe), 0);
        chk("midrst_tag", 32'(obsTag), 0);
        chk("midrst_done", 32'(obsDone), 0);
        chk("midrst_busy", 32'(obsBusy), 0);
        chk("midrst_stall", 32'(obsStall), 1);
        next_cycle();
        rst_n = 1'b1;
        missA = 2'b00;
        for (int c = 0; c < 4; c++) begin
            rvalid = 1'b1;
            rdata  = 16'hBAD0 + 16'(c);
            @(negedge clk);
            chk($sformatf("stray%0d_we", c), 32'(obsWe), 0);
            chk($sformatf("stray%0d_tag", c), 32'(obsTag), 0);
            chk($sformatf("stray%0d_done", c), 32'(obsDone), 0);
            chk($sformatf("stray%0d_busy", c), 32'(obsBusy), 0);
            next_cycle();
        end
        rvalid = 1'b0;

        // Four-word, single-requester instance; return pulse in IDLE first.
        sel    = 1;
        rvalid = 1'b1;
        rdata  = 16'h1111;
        @(negedge clk);
        chk("b_idle_ret_we", 32'(obsWe), 0);
        chk("b_idle_ret_busy", 32'(obsBusy), 0);
        next_cycle();
        rvalid = 1'b0;
        missB = 1'b1;
        addrB = 16'h00FF;
        run_fill(1, 0, 16'h00FF, 4, 2, zg);
        missB = 1'b0;
        @(negedge clk);
        chk("b_end_busy", 32'(obsBusy), 0);
        chk("b_end_stall", 32'(obsStall), 0);
        next_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
